// File: rtl/gen_dualpop_fifo.sv
// In-order FIFO with one enqueue port and two dequeue ports (A = oldest, B = next-oldest).
// A downstream stage may retire zero, one or two entries per cycle; B never retires without A.
module gen_dualpop_fifo #(
    parameter int              DW       = 32,
    parameter int              DP       = 4,
    parameter logic [DW-1:0]   rstValue = {DW{1'b0}},
    localparam int             AW       = $clog2(DP),
    localparam int             CW       = $clog2(DP) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          a_valid,
    output logic [DW-1:0] a_data,
    input  logic          a_ready,
    output logic          b_valid,
    output logic [DW-1:0] b_data,
    input  logic          b_ready,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_reg [DP];
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] rd_ptr_p1;

    logic push_fire;
    logic a_fire;
    logic b_fire;

    // Outputs are derived from registered state only (plus RST for push_ready).
    assign push_ready = ~RST & (count_reg != CW'(DP));
    assign a_valid    = (count_reg != '0);
    assign b_valid    = (count_reg > CW'(1));
    assign rd_ptr_p1  = rd_ptr_reg + AW'(1);
    assign a_data     = mem_reg[rd_ptr_reg];
    assign b_data     = mem_reg[rd_ptr_p1];
    assign count      = count_reg;

    assign push_fire = push_valid & push_ready;
    assign a_fire    = a_valid & a_ready;
    assign b_fire    = b_valid & b_ready & a_fire;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            rd_ptr_next = rd_ptr_reg + AW'(a_fire) + AW'(b_fire);
            count_next  = count_reg + CW'(push_fire) - CW'(a_fire) - CW'(b_fire);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Each entry owns its write decode; flush leaves contents intact but blocks the write.
    generate
        for (genvar gi = 0; gi < DP; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (RST) begin
                    mem_reg[gi] <= rstValue;
                end else if (!flush && push_fire && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_gen_dualpop_fifo.sv
// Directed bench for gen_dualpop_fifo: a vector table applied one cycle per row,
// plus hand sequences for reset-time push_ready behaviour.
module tb_gen_dualpop_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam logic [7:0] RSTV = 8'hA5;

    logic       CLK = 1'b0;
    logic       RST;
    logic       flush;
    logic       push_valid;
    logic [7:0] push_data;
    logic       push_ready;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    gen_dualpop_fifo #(.DW(DW), .DP(DP), .rstValue(RSTV)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .count(count)
    );

    typedef struct {
        logic       rst;
        logic       fl;
        logic       pv;
        logic [7:0] pd;
        logic       ar;
        logic       br;
        logic [2:0] cnt;
        logic       pr;
        logic       av;
        logic       bv;
        logic [7:0] ad;
        logic [7:0] bd;
        logic [1:0] rd;
    } vec_t;

    localparam int NV = 33;
    vec_t vec [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        RST = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = 8'h00;
        a_ready = 1'b0; b_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] diff;
        //             rst fl pv pd     ar br  cnt  pr av bv ad     bd     rd
        vec[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,3'd0,1'b1,1'b0,1'b0,8'hA5,8'hA5,2'd0};
        vec[1]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,3'd0,1'b1,1'b0,1'b0,8'hA5,8'hA5,2'd0};
        vec[2]  = '{1'b0,1'b0,1'b1,8'h11,1'b0,1'b0,3'd1,1'b1,1'b1,1'b0,8'h11,8'hA5,2'd0};
        vec[3]  = '{1'b0,1'b0,1'b1,8'h22,1'b0,1'b0,3'd2,1'b1,1'b1,1'b1,8'h11,8'h22,2'd0};
        vec[4]  = '{1'b0,1'b0,1'b1,8'h33,1'b0,1'b0,3'd3,1'b1,1'b1,1'b1,8'h11,8'h22,2'd0};
        vec[5]  = '{1'b0,1'b0,1'b1,8'h44,1'b0,1'b0,3'd4,1'b0,1'b1,1'b1,8'h11,8'h22,2'd0};
        vec[6]  = '{1'b0,1'b0,1'b1,8'h55,1'b0,1'b0,3'd4,1'b0,1'b1,1'b1,8'h11,8'h22,2'd0};
        vec[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,3'd2,1'b1,1'b1,1'b1,8'h33,8'h44,2'd2};
        vec[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,3'd0,1'b1,1'b0,1'b0,8'h11,8'h22,2'd0};
        vec[9]  = '{1'b0,1'b0,1'b1,8'h61,1'b0,1'b0,3'd1,1'b1,1'b1,1'b0,8'h61,8'h22,2'd0};
        vec[10] = '{1'b0,1'b0,1'b1,8'h62,1'b1,1'b0,3'd1,1'b1,1'b1,1'b0,8'h62,8'h33,2'd1};
        vec[11] = '{1'b0,1'b0,1'b1,8'h63,1'b1,1'b0,3'd1,1'b1,1'b1,1'b0,8'h63,8'h44,2'd2};
        vec[12] = '{1'b0,1'b0,1'b1,8'h64,1'b1,1'b0,3'd1,1'b1,1'b1,1'b0,8'h64,8'h61,2'd3};
        vec[13] = '{1'b0,1'b0,1'b1,8'h65,1'b0,1'b0,3'd2,1'b1,1'b1,1'b1,8'h64,8'h65,2'd3};
        vec[14] = '{1'b0,1'b0,1'b1,8'h66,1'b0,1'b0,3'd3,1'b1,1'b1,1'b1,8'h64,8'h65,2'd3};
        vec[15] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,3'd1,1'b1,1'b1,1'b0,8'h66,8'h63,2'd1};
        vec[16] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,3'd0,1'b1,1'b0,1'b0,8'h65,8'h66,2'd0};
        vec[17] = '{1'b0,1'b0,1'b1,8'h0A,1'b0,1'b0,3'd1,1'b1,1'b1,1'b0,8'h0A,8'h66,2'd0};
        vec[18] = '{1'b0,1'b0,1'b1,8'h0B,1'b0,1'b0,3'd2,1'b1,1'b1,1'b1,8'h0A,8'h0B,2'd0};
        vec[19] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,3'd2,1'b1,1'b1,1'b1,8'h0A,8'h0B,2'd0};
        vec[20] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,3'd0,1'b1,1'b0,1'b0,8'h63,8'h64,2'd2};
        vec[21] = '{1'b0,1'b0,1'b1,8'h01,1'b0,1'b0,3'd1,1'b1,1'b1,1'b0,8'h01,8'h64,2'd2};
        vec[22] = '{1'b0,1'b0,1'b1,8'h02,1'b0,1'b0,3'd2,1'b1,1'b1,1'b1,8'h01,8'h02,2'd2};
        vec[23] = '{1'b0,1'b0,1'b1,8'h03,1'b1,1'b1,3'd1,1'b1,1'b1,1'b0,8'h03,8'h0B,2'd0};
        vec[24] = '{1'b0,1'b0,1'b1,8'h04,1'b0,1'b0,3'd2,1'b1,1'b1,1'b1,8'h03,8'h04,2'd0};
        vec[25] = '{1'b0,1'b0,1'b1,8'h05,1'b0,1'b0,3'd3,1'b1,1'b1,1'b1,8'h03,8'h04,2'd0};
        vec[26] = '{1'b0,1'b0,1'b1,8'h06,1'b0,1'b0,3'd4,1'b0,1'b1,1'b1,8'h03,8'h04,2'd0};
        vec[27] = '{1'b0,1'b0,1'b1,8'h07,1'b1,1'b0,3'd3,1'b1,1'b1,1'b1,8'h04,8'h05,2'd1};
        vec[28] = '{1'b0,1'b1,1'b1,8'h08,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,8'h03,8'h04,2'd0};
        vec[29] = '{1'b0,1'b0,1'b1,8'h09,1'b0,1'b0,3'd1,1'b1,1'b1,1'b0,8'h09,8'h04,2'd0};
        vec[30] = '{1'b0,1'b0,1'b1,8'h0A,1'b0,1'b0,3'd2,1'b1,1'b1,1'b1,8'h09,8'h0A,2'd0};
        vec[31] = '{1'b0,1'b0,1'b1,8'h0B,1'b0,1'b0,3'd3,1'b1,1'b1,1'b1,8'h09,8'h0A,2'd0};
        vec[32] = '{1'b1,1'b0,1'b1,8'h0C,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,8'hA5,8'hA5,2'd0};

        idle();
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            RST = vec[i].rst; flush = vec[i].fl; push_valid = vec[i].pv;
            push_data = vec[i].pd; a_ready = vec[i].ar; b_ready = vec[i].br;
            @(posedge CLK);
            #1 idle();
            #1;
            chk("count", i, 32'(count), 32'(vec[i].cnt));
            chk("push_ready", i, 32'(push_ready), 32'(vec[i].pr));
            chk("a_valid", i, 32'(a_valid), 32'(vec[i].av));
            chk("b_valid", i, 32'(b_valid), 32'(vec[i].bv));
            chk("a_data", i, 32'(a_data), 32'(vec[i].ad));
            chk("b_data", i, 32'(b_data), 32'(vec[i].bd));
            chk("rd_ptr", i, 32'(dut.rd_ptr_reg), 32'(vec[i].rd));
            diff = dut.wr_ptr_reg - dut.rd_ptr_reg;
            chk("inv_ptr_diff", i, 32'(diff), 32'(vec[i].cnt[1:0]));
            chk("inv_b_implies_a", i, 32'(b_valid & ~a_valid), 32'd0);
            $display("row %0d: cnt=%0d pr=%0b av=%0b bv=%0b a=%02h b=%02h", i, count, push_ready,
                     a_valid, b_valid, a_data, b_data);
        end

        // push_ready must drop combinationally while RST is high, even from empty.
        @(negedge CLK);
        RST = 1'b1;
        push_valid = 1'b1; push_data = 8'h77;
        #1 chk("push_ready_in_rst", 100, 32'(push_ready), 32'd0);
        @(posedge CLK);
        #1 chk("push_ready_in_rst_after_edge", 101, 32'(push_ready), 32'd0);
        chk("count_in_rst", 101, 32'(count), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1 chk("push_ready_after_rst", 102, 32'(push_ready), 32'd1);
        @(posedge CLK);
        #1 idle();
        #1;
        chk("post_rst_push_count", 103, 32'(count), 32'd1);
        chk("post_rst_push_a_data", 103, 32'(a_data), 32'h77);
        $display("rst sequence: cnt=%0d a=%02h pr=%0b", count, a_data, push_ready);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gen_dualpop_fifo.md
# gen_dualpop_fifo

In-order FIFO with one enqueue port and two dequeue ports. It is the read-side counterpart to the team's dual-write priority flop: there, two sources with fixed priority (A over B) merge into one register; here, one source fans out to two consumers with fixed priority (A over B). Port A always presents the oldest entry and port B the next-oldest, so a downstream stage can retire zero, one or two entries per cycle without reordering. Typical use is between a fetch/decode producer and a two-wide issue stage.

## Interface

**Parameters**
- DW, 32, data width in bits.
- DP, 4, depth in entries. Must be a power of two and at least 2.
- rstValue, {DW{1'b0}}, reset value of every storage entry.

**Ports**
- CLK, input, 1, clock. All state updates on the rising edge.
- RST, input, 1, reset. Synchronous, active-high.
- flush, input, 1, synchronous clear of all entries.
- push_valid, input, 1, enqueue request.
- push_data, input, DW, enqueue data.
- push_ready, output, 1, FIFO can accept an entry this cycle.
- a_valid, output, 1, the head entry is present.
- a_data, output, DW, the head (oldest) entry.
- a_ready, input, 1, consumer A takes the head.
- b_valid, output, 1, the second-oldest entry is present.
- b_data, output, DW, the second-oldest entry.
- b_ready, input, 1, consumer B takes the second entry.
- count, output, $clog2(DP)+1, number of valid entries (0..DP).

## Operation

**State**
- Storage: DP × DW registers.
- Pointers: rd_ptr and wr_ptr, each $clog2(DP) bits, wrapping modulo DP.
- Occupancy: count register.

**Fire conditions**
- push_fire = push_valid & push_ready.
- a_fire = a_valid & a_ready.
- b_fire = b_valid & b_ready & a_fire.
- B never dequeues alone. b_ready without a_fire has no effect. This keeps dequeue strictly in order, with A having priority over B.

**Outputs**
- push_ready = ~RST & (count != DP). There is no push-while-full bypass, even if a pop occurs the same cycle.
- a_valid = (count >= 1). a_data = mem[rd_ptr].
- b_valid = (count >= 2). b_data = mem[rd_ptr+1 mod DP].

**Update each cycle, in priority order**
1. RST: rd_ptr = wr_ptr = 0, count = 0, every mem entry = rstValue.
2. Else flush: rd_ptr = wr_ptr = 0, count = 0. mem is unchanged. push, a_ready and b_ready are ignored that cycle.
3. Otherwise, apply all of the following in the same cycle:
   - On push_fire: write mem[wr_ptr] = push_data and advance wr_ptr by 1.
   - Advance rd_ptr by a_fire + b_fire (0, 1 or 2).
   - Set count = count + push_fire − a_fire − b_fire.
- Push and dual pop in the same cycle are legal at any occupancy that allows them. When count==2 with push and dual pop, the new entry is written and count becomes 1.
- Pointer wrap: rd_ptr+2 wraps modulo DP. For example, with DP=4 and rd_ptr=3, a dual pop gives rd_ptr=1.

**Invariants (assert in bench)**
- count ≤ DP at all times.
- wr_ptr − rd_ptr ≡ count (mod DP).
- b_valid implies a_valid.

## Timing

**Reset values** (in the cycle after RST is sampled high)
- push_ready = 1
- a_valid = 0, b_valid = 0
- a_data = b_data = rstValue
- count = 0
- push_ready is 0 while RST is high.

**Latency**
- An entry pushed at edge N is visible on a_data/a_valid after edge N. There is no same-cycle push-to-pop bypass.
- An entry is visible on port B one cycle after the edge that makes count ≥ 2.

**Throughput**
- 1 push/cycle, 2 pops/cycle.

**Combinational paths**
- All outputs depend only on registers and RST.
- There is no combinational path from any ready or valid input to any output.

**Mid-operation events**
- flush or RST mid-stream discards all entries. The next cycle shows count = 0 and both valid outputs low.

## Test plan

1. **Reset then fill.** RST for 2 cycles, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with DP=4 and no pops.
   - Expect count 1, 2, 3, 4.
   - push_ready falls to 0 after the 4th push.
   - a_data = 0x11, b_data = 0x22.
   - A 5th push_valid is not accepted and count stays 4.
2. **Dual pop with wrap.** From the full state, assert a_ready & b_ready for 2 cycles.
   - Cycle 1 presents 0x11/0x22; cycle 2 presents 0x33/0x44.
   - Afterwards count = 0, rd_ptr = 0, both valids low.
   - Repeat starting from rd_ptr = 3 and check the wrap to 1.
3. **B-only ignored.** With count = 2 holding 0xA/0xB, assert b_ready=1 and a_ready=0.
   - Expect no change: count stays 2 and a_data stays 0xA.
4. **Simultaneous push and dual pop.** With count = 2 holding 0x1/0x2, push 0x3 with a_ready = b_ready = 1.
   - Next cycle: count = 1, a_data = 0x3, b_valid = 0.
5. **Single pop with push at full.** At count = 4, push_valid=1 and a_ready=1.
   - The pop is accepted and the push is rejected (push_ready=0 that cycle).
   - count becomes 3, then push_ready returns to 1.
6. **Flush and reset mid-stream.**
   - With count = 3, assert flush together with push_valid and a_ready: next cycle count = 0 and the pushed data is dropped.
   - Repeat with RST instead of flush: additionally a_data reads rstValue.
